// File: rtl/uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned DEFAULT_DATA_WIDTH   = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic bit_end
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a FIFO read port and sends each as an 8N1 UART frame, LSB first.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick
);

    localparam int unsigned IW = $clog2(DATA_WIDTH);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;
    logic                  clr;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        rd           = 1'b0;
        tx_done_tick = 1'b0;
        case (state_q)
            IDLE: begin
                if (reset && en && !empty) begin
                    rd      = 1'b1;
                    shreg_d = r_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IW'(DATA_WIDTH - 1)) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done_tick = reset;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        clr = (state_d != state_q);

        // tx is registered from the next state so the line follows rd by exactly one edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: queue-backed FIFO model and frame-timeline reference for fifo_uart_tx.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int FRAME = (DW + 2) * CPB;

    logic          clk;
    logic          reset;
    logic          en;
    logic          empty;
    logic [DW-1:0] r_data;
    logic          rd;
    logic          tx;
    logic          tx_busy;
    logic          tx_done_tick;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .empty       (empty),
        .r_data      (r_data),
        .rd          (rd),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done_tick(tx_done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] q[$];
    int            total  = 0;
    int            passed = 0;
    logic          rst_n  = 1'b0;
    logic          en_v   = 1'b0;
    logic          chk_en = 1'b0;
    int            fcyc   = -1;
    logic [DW+1:0] frame  = '1;
    int            cyc    = 0;
    int            rd_cyc[$];
    int            done_cyc = -1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    // One clock cycle: drive inputs, compare against the frame timeline, advance the model.
    task automatic tick();
        logic idle, rd_exp, tx_exp, busy_exp, done_exp;
        @(negedge clk);
        reset  = rst_n;
        en     = en_v;
        empty  = (q.size() == 0);
        r_data = (q.size() != 0) ? q[0] : DW'($urandom);
        #1;
        idle     = (fcyc < 0);
        rd_exp   = rst_n && en_v && (q.size() != 0) && idle;
        tx_exp   = idle ? 1'b1 : frame[fcyc / CPB];
        busy_exp = !idle;
        done_exp = rst_n && (fcyc == FRAME - 1);
        if (chk_en) begin
            check("rd", 8'(rd), 8'(rd_exp));
            check("tx", 8'(tx), 8'(tx_exp));
            check("tx_busy", 8'(tx_busy), 8'(busy_exp));
            check("tx_done_tick", 8'(tx_done_tick), 8'(done_exp));
        end
        if (rd === 1'b1) rd_cyc.push_back(cyc);
        if (tx_done_tick === 1'b1) done_cyc = cyc;
        if (!rst_n) begin
            fcyc = -1;
        end else if (rd_exp) begin
            frame = {1'b1, q.pop_front(), 1'b0};
            fcyc  = 0;
        end else if (fcyc >= 0) begin
            fcyc++;
            if (fcyc == FRAME) fcyc = -1;
        end
        cyc++;
    endtask

    initial begin
        reset  = 1'b0;
        en     = 1'b0;
        empty  = 1'b1;
        r_data = '0;

        // Reset held three cycles with FIFO empty, then released.
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Single word 0xA5.
        en_v = 1'b1;
        q.push_back(8'hA5);
        repeat (FRAME + 5) tick();
        check("rd_count_a5", 8'(rd_cyc.size()), 8'd1);
        check("done_latency", 8'(done_cyc - rd_cyc[rd_cyc.size()-1]), 8'(FRAME));

        // Back-to-back words 0x00, 0xFF.
        q.push_back(8'h00);
        q.push_back(8'hFF);
        repeat (2 * FRAME + 10) tick();
        check("rd_count_b2b", 8'(rd_cyc.size()), 8'd3);
        check("rd_spacing", 8'(rd_cyc[2] - rd_cyc[1]), 8'(FRAME + 1));

        // en dropped during DATA of 0x3C; a pending word must wait.
        q.push_back(8'h3C);
        repeat (11) tick();
        en_v = 1'b0;
        q.push_back(8'h11);
        repeat (FRAME + 10) tick();
        check("rd_held_en0", 8'(rd_cyc.size()), 8'd4);
        en_v = 1'b1;
        repeat (FRAME + 5) tick();
        check("rd_after_en", 8'(rd_cyc.size()), 8'd5);

        // Reset during bit 3 of 0x81, then a fresh frame.
        q.push_back(8'h81);
        repeat (18) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("no_rd_after_abort", 8'(rd_cyc.size()), 8'd6);
        q.push_back(8'h5A);
        repeat (FRAME + 5) tick();
        check("rd_after_reset", 8'(rd_cyc.size()), 8'd7);

        // FIFO empty mid-frame, then refilled before the frame ends.
        q.push_back(8'h96);
        repeat (20) tick();
        q.push_back(8'h77);
        repeat (2 * FRAME + 10) tick();
        check("rd_count_refill", 8'(rd_cyc.size()), 8'd9);

        // Randomised traffic with en toggling.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(11) == 0 && q.size() < 4) q.push_back(DW'($urandom));
            if ($urandom_range(39) == 0) en_v = ~en_v;
            tick();
        end
        en_v = 1'b1;
        repeat (5 * (FRAME + 1) + 10) tick();
        check("drained", 8'(q.size()), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
